// File: rtl/sdc_pkg.sv
// Shared definitions for the SD-card DMA controller.
//   - register word indices on the Wishbone slave
//   - CTRL / STATUS bit positions
//   - sequencer state encoding and the sticky completion-flag bundle
package sdc_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_BASE    = 3'd2;
    localparam logic [2:0] REG_LEN     = 3'd3;
    localparam logic [2:0] REG_TIMEOUT = 3'd4;
    localparam logic [2:0] REG_REMAIN  = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_ABORTED  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_e;

    typedef struct packed {
        logic aborted;
        logic timeout;
        logic done;
    } flags_t;

endpackage

// File: rtl/sdc_dma_ctrl_if.sv
// Wishbone slave bus for the SD DMA controller register block.
//   wbs_adr    register word index (byte address bits [4:2])
//   wbs_dat_i  write data          wbs_dat_o  read data
//   wbs_cyc/wbs_stb/wbs_we        bus strobes
//   wbs_ack    single-cycle acknowledge
interface sdc_dma_ctrl_if;
    logic [2:0]  wbs_adr;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic        wbs_we;
    logic        wbs_ack;

    modport slave (
        input  wbs_adr, wbs_dat_i, wbs_cyc, wbs_stb, wbs_we,
        output wbs_dat_o, wbs_ack
    );

    modport master (
        output wbs_adr, wbs_dat_i, wbs_cyc, wbs_stb, wbs_we,
        input  wbs_dat_o, wbs_ack
    );
endinterface

// File: rtl/sdc_dma_regs.sv
// Register file for the SD DMA controller: Wishbone slave decode, ack
// generation, software-visible registers and the sticky W1C status flags.
//   wb_clk, s_rst        clock, synchronous active-high reset
//   wb                   Wishbone slave port
//   busy, remain         sequencer status for STATUS/REMAIN reads
//   set_*, clr_flags     sequencer requests on the sticky flags
//   start_req, abort_req one-cycle pulses from CTRL writes
//   dir, len, timeout    programmed transfer setup
//   dma_base_addr        word-aligned start address to the DMA
//   irq                  registered level interrupt
module sdc_dma_regs
    import sdc_pkg::*;
#(
    parameter int              LEN_W      = 16,
    parameter int              TO_W       = 24,
    parameter logic [TO_W-1:0] TO_DEFAULT = 24'hFFFFFF
) (
    input  logic              wb_clk,
    input  logic              s_rst,
    sdc_dma_ctrl_if.slave     wb,
    input  logic              busy,
    input  logic [LEN_W-1:0]  remain,
    input  logic              set_done,
    input  logic              set_timeout,
    input  logic              set_aborted,
    input  logic              clr_flags,
    output logic              start_req,
    output logic              abort_req,
    output logic              dir,
    output logic [LEN_W-1:0]  len,
    output logic [TO_W-1:0]   timeout,
    output logic [31:0]       dma_base_addr,
    output logic              irq
);

    logic        acc;
    logic        wr;
    logic        irq_en;
    logic [29:0] base_hi;
    flags_t      flags;
    flags_t      flags_nxt;
    logic [31:0] rd_mux;

    // A request is taken only while ack is low, which makes ack a single
    // pulse and rules out back-to-back acknowledges.
    assign acc = wb.wbs_cyc & wb.wbs_stb & ~wb.wbs_ack;
    assign wr  = acc & wb.wbs_we;

    assign start_req = wr && (wb.wbs_adr == REG_CTRL) && wb.wbs_dat_i[CTRL_START];
    assign abort_req = wr && (wb.wbs_adr == REG_CTRL) && wb.wbs_dat_i[CTRL_ABORT];

    always_comb begin
        rd_mux = '0;
        case (wb.wbs_adr)
            REG_CTRL: begin
                rd_mux[CTRL_DIR]    = dir;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            REG_STATUS: begin
                rd_mux[ST_BUSY]    = busy;
                rd_mux[ST_DONE]    = flags.done;
                rd_mux[ST_TIMEOUT] = flags.timeout;
                rd_mux[ST_ABORTED] = flags.aborted;
            end
            REG_BASE:    rd_mux            = {base_hi, 2'b00};
            REG_LEN:     rd_mux[LEN_W-1:0] = len;
            REG_TIMEOUT: rd_mux[TO_W-1:0]  = timeout;
            REG_REMAIN:  rd_mux[LEN_W-1:0] = remain;
            default:     rd_mux            = '0;
        endcase
    end

    // Hardware set beats a software clear in the same cycle so an event is
    // never lost; a fresh start wipes the previous result first.
    always_comb begin
        flags_nxt = flags;
        if (wr && (wb.wbs_adr == REG_STATUS)) begin
            if (wb.wbs_dat_i[ST_DONE])    flags_nxt.done    = 1'b0;
            if (wb.wbs_dat_i[ST_TIMEOUT]) flags_nxt.timeout = 1'b0;
            if (wb.wbs_dat_i[ST_ABORTED]) flags_nxt.aborted = 1'b0;
        end
        if (clr_flags)   flags_nxt         = '0;
        if (set_done)    flags_nxt.done    = 1'b1;
        if (set_timeout) flags_nxt.timeout = 1'b1;
        if (set_aborted) flags_nxt.aborted = 1'b1;
    end

    always_ff @(posedge wb_clk) begin
        if (s_rst) begin
            wb.wbs_ack    <= 1'b0;
            wb.wbs_dat_o  <= '0;
            dir           <= 1'b0;
            irq_en        <= 1'b0;
            base_hi       <= '0;
            len           <= '0;
            timeout       <= TO_DEFAULT;
            flags         <= '0;
            dma_base_addr <= '0;
            irq           <= 1'b0;
        end else begin
            wb.wbs_ack <= acc;
            if (acc && !wb.wbs_we)
                wb.wbs_dat_o <= rd_mux;

            if (wr) begin
                case (wb.wbs_adr)
                    REG_CTRL: begin
                        irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
                        if (!busy) dir <= wb.wbs_dat_i[CTRL_DIR];
                    end
                    REG_BASE:    if (!busy) base_hi <= wb.wbs_dat_i[31:2];
                    REG_LEN:     if (!busy) len     <= wb.wbs_dat_i[LEN_W-1:0];
                    REG_TIMEOUT: timeout <= wb.wbs_dat_i[TO_W-1:0];
                    default: ;
                endcase
            end

            flags <= flags_nxt;

            // Address seen by the DMA is frozen for the whole transfer.
            if (!busy)
                dma_base_addr <= {base_hi, 2'b00};

            irq <= irq_en & (|flags);
        end
    end

endmodule

// File: rtl/sdc_dma_ctrl.sv
// SD-card DMA controller: register block plus transfer sequencer.
// Software programs BASE/LEN/dir/TIMEOUT and starts a transfer; the
// sequencer arms the DMA, enables one direction, counts master beats,
// waits for the SD datapath to drain on tx, and reports done / timeout /
// aborted.
//   wb_clk, s_rst   clock, synchronous active-high reset
//   wb              Wishbone slave register port
//   dma_tx_en       memory->SD enable      dma_rx_en  SD->memory enable
//   dma_base_addr   start address to DMA   dma_beat   one word moved
//   sd_idle         SD datapath idle       irq        level interrupt
module sdc_dma_ctrl
    import sdc_pkg::*;
#(
    parameter int              LEN_W      = 16,
    parameter int              TO_W       = 24,
    parameter logic [TO_W-1:0] TO_DEFAULT = 24'hFFFFFF
) (
    input  logic          wb_clk,
    input  logic          s_rst,
    sdc_dma_ctrl_if.slave wb,
    output logic          dma_tx_en,
    output logic          dma_rx_en,
    output logic [31:0]   dma_base_addr,
    input  logic          dma_beat,
    input  logic          sd_idle,
    output logic          irq
);

    state_e           state, state_nxt;
    logic [LEN_W-1:0] remain, remain_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic             set_done, set_timeout, set_aborted, clr_flags;
    logic             start_req, abort_req, dir;
    logic [LEN_W-1:0] len;
    logic [TO_W-1:0]  timeout;
    logic             busy;
    logic             beat_ok, last_beat, to_expire;

    assign busy      = (state != IDLE);
    // Beats with nothing left to move are dropped; the counter never wraps.
    assign beat_ok   = dma_beat && (remain != '0);
    assign last_beat = beat_ok && (remain == LEN_W'(1));
    // This idle cycle takes the inactivity counter to zero.
    assign to_expire = (to_cnt <= TO_W'(1));

    sdc_dma_regs #(
        .LEN_W      (LEN_W),
        .TO_W       (TO_W),
        .TO_DEFAULT (TO_DEFAULT)
    ) u_regs (
        .wb_clk        (wb_clk),
        .s_rst         (s_rst),
        .wb            (wb),
        .busy          (busy),
        .remain        (remain),
        .set_done      (set_done),
        .set_timeout   (set_timeout),
        .set_aborted   (set_aborted),
        .clr_flags     (clr_flags),
        .start_req     (start_req),
        .abort_req     (abort_req),
        .dir           (dir),
        .len           (len),
        .timeout       (timeout),
        .dma_base_addr (dma_base_addr),
        .irq           (irq)
    );

    always_comb begin
        state_nxt   = state;
        remain_nxt  = remain;
        to_nxt      = to_cnt;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        set_aborted = 1'b0;
        clr_flags   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    remain_nxt = len;
                    to_nxt     = timeout;
                    clr_flags  = 1'b1;
                    state_nxt  = (len == '0) ? FIN : ARM;
                end
            end
            // Both enables low for one cycle so the DMA latches its address.
            ARM: begin
                if (abort_req) begin
                    set_aborted = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (beat_ok) begin
                    remain_nxt = remain - LEN_W'(1);
                    to_nxt     = timeout;
                end else if (!to_expire) begin
                    to_nxt = to_cnt - TO_W'(1);
                end
                // The final beat completes the transfer even if an abort
                // lands in the same cycle.
                if (last_beat) begin
                    state_nxt = dir ? DRAIN : FIN;
                end else if (abort_req) begin
                    set_aborted = 1'b1;
                    state_nxt   = IDLE;
                end else if (!beat_ok && to_expire) begin
                    set_timeout = 1'b1;
                    to_nxt      = '0;
                    state_nxt   = IDLE;
                end
            end
            // tx only: memory side is finished, wait for the card to drain.
            DRAIN: begin
                if (abort_req) begin
                    set_aborted = 1'b1;
                    state_nxt   = IDLE;
                end else if (sd_idle) begin
                    state_nxt = FIN;
                end else if (to_expire) begin
                    set_timeout = 1'b1;
                    to_nxt      = '0;
                    state_nxt   = IDLE;
                end else begin
                    to_nxt = to_cnt - TO_W'(1);
                end
            end
            FIN: begin
                set_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables are registered from the next state, so they follow every
    // state change (completion, abort, timeout) on the very next edge.
    always_ff @(posedge wb_clk) begin
        if (s_rst) begin
            state     <= IDLE;
            remain    <= '0;
            to_cnt    <= '0;
            dma_tx_en <= 1'b0;
            dma_rx_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            remain    <= remain_nxt;
            to_cnt    <= to_nxt;
            dma_tx_en <= (state_nxt == RUN) &  dir;
            dma_rx_en <= (state_nxt == RUN) & ~dir;
        end
    end

endmodule

// File: tb/tb_sdc_dma_ctrl.sv
// Directed bench for sdc_dma_ctrl: register access, rx/tx transfers,
// drain, timeout, abort races, busy write-protection, reset and W1C.
module tb_sdc_dma_ctrl;
    import sdc_pkg::*;

    logic        wb_clk   = 1'b0;
    logic        s_rst    = 1'b1;
    logic        dma_beat = 1'b0;
    logic        sd_idle  = 1'b1;
    logic        dma_tx_en, dma_rx_en, irq;
    logic [31:0] dma_base_addr;
    int          n_assert = 0;
    int          n_fail   = 0;

    sdc_dma_ctrl_if wb();

    sdc_dma_ctrl #(
        .LEN_W      (16),
        .TO_W       (24),
        .TO_DEFAULT (24'hFFFFFF)
    ) dut (
        .wb_clk        (wb_clk),
        .s_rst         (s_rst),
        .wb            (wb),
        .dma_tx_en     (dma_tx_en),
        .dma_rx_en     (dma_rx_en),
        .dma_base_addr (dma_base_addr),
        .dma_beat      (dma_beat),
        .sd_idle       (sd_idle),
        .irq           (irq)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        int n = 0;
        wb.wbs_adr   = a;
        wb.wbs_dat_i = d;
        wb.wbs_we    = we;
        wb.wbs_cyc   = 1'b1;
        wb.wbs_stb   = 1'b1;
        do begin
            tick();
            n++;
        end while (wb.wbs_ack !== 1'b1 && n < 8);
        q = wb.wbs_dat_o;
        wb.wbs_cyc = 1'b0;
        wb.wbs_stb = 1'b0;
        wb.wbs_we  = 1'b0;
        if (wb.wbs_ack !== 1'b1) chk("ack_timeout", 32'(wb.wbs_ack), 32'd1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'd0, q);
        chk(tag, q, exp);
    endtask

    initial begin
        wb.wbs_adr   = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_cyc   = 1'b0;
        wb.wbs_stb   = 1'b0;
        wb.wbs_we    = 1'b0;
        repeat (3) tick();
        s_rst = 1'b0;

        // reset state
        chk("rst_ack",   32'(wb.wbs_ack), 32'd0);
        chk("rst_dat_o", wb.wbs_dat_o,    32'd0);
        chk("rst_tx",    32'(dma_tx_en),  32'd0);
        chk("rst_rx",    32'(dma_rx_en),  32'd0);
        chk("rst_base",  dma_base_addr,   32'd0);
        chk("rst_irq",   32'(irq),        32'd0);
        chk("rst_state", 32'(dut.state),  32'(IDLE));
        rdchk("rst_timeout", REG_TIMEOUT, 32'h00FF_FFFF);
        rdchk("rst_status",  REG_STATUS,  32'd0);
        rdchk("rst_len",     REG_LEN,     32'd0);
        rdchk("idx6_zero",   3'd6,        32'd0);

        // rx transfer, BASE=0x1000, LEN=4, irq_en
        wr(REG_BASE, 32'h0000_1003);
        rdchk("base_lsb_zero", REG_BASE, 32'h0000_1000);
        wr(REG_LEN, 32'd4);
        wr(REG_CTRL, 32'h9);
        chk("rx_arm_state", 32'(dut.state),  32'(ARM));
        chk("rx_arm_rx",    32'(dma_rx_en),  32'd0);
        chk("rx_arm_tx",    32'(dma_tx_en),  32'd0);
        chk("rx_dma_base",  dma_base_addr,   32'h0000_1000);
        tick();
        chk("rx_run_rx", 32'(dma_rx_en), 32'd1);
        chk("rx_run_tx", 32'(dma_tx_en), 32'd0);
        dma_beat = 1'b1;
        repeat (3) tick();
        chk("rx_beat3_rx", 32'(dma_rx_en), 32'd1);
        tick();
        dma_beat = 1'b0;
        chk("rx_beat4_rx",  32'(dma_rx_en), 32'd0);
        chk("rx_fin_state", 32'(dut.state), 32'(FIN));
        tick();
        chk("rx_idle_state", 32'(dut.state), 32'(IDLE));
        rdchk("rx_status", REG_STATUS, 32'h2);
        chk("rx_irq", 32'(irq), 32'd1);
        rdchk("rx_remain", REG_REMAIN, 32'd0);
        rdchk("rx_ctrl",   REG_CTRL,   32'h8);

        // tx transfer, LEN=128, drain held for 10 cycles
        wr(REG_LEN, 32'd128);
        sd_idle = 1'b0;
        wr(REG_CTRL, 32'hB);
        tick();
        chk("tx_run_tx", 32'(dma_tx_en), 32'd1);
        chk("tx_run_rx", 32'(dma_rx_en), 32'd0);
        dma_beat = 1'b1;
        repeat (127) tick();
        chk("tx_beat127_tx", 32'(dma_tx_en), 32'd1);
        tick();
        dma_beat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("tx_drain_state", 32'(dut.state), 32'(DRAIN));
            chk("tx_drain_en",    32'(dma_tx_en), 32'd0);
            if (i == 9) sd_idle = 1'b1;
            tick();
        end
        chk("tx_fin_state", 32'(dut.state), 32'(FIN));
        tick();
        chk("tx_idle_state", 32'(dut.state), 32'(IDLE));
        rdchk("tx_status", REG_STATUS, 32'h2);
        rdchk("tx_remain", REG_REMAIN, 32'd0);

        // inactivity timeout: TIMEOUT=8, LEN=3, one beat then silence
        wr(REG_TIMEOUT, 32'd8);
        wr(REG_LEN, 32'd3);
        wr(REG_CTRL, 32'h1);
        tick();
        chk("to_run_rx", 32'(dma_rx_en), 32'd1);
        dma_beat = 1'b1;
        tick();
        dma_beat = 1'b0;
        repeat (7) tick();
        chk("to_7idle_rx",    32'(dma_rx_en), 32'd1);
        chk("to_7idle_state", 32'(dut.state), 32'(RUN));
        tick();
        chk("to_8idle_rx",    32'(dma_rx_en), 32'd0);
        chk("to_8idle_state", 32'(dut.state), 32'(IDLE));
        rdchk("to_status", REG_STATUS, 32'h4);
        rdchk("to_remain", REG_REMAIN, 32'd2);
        chk("to_irq_off", 32'(irq), 32'd0);

        // abort on the final beat: done wins
        wr(REG_LEN, 32'd2);
        wr(REG_CTRL, 32'h9);
        tick();
        dma_beat = 1'b1;
        tick();
        wr(REG_CTRL, 32'hC);
        dma_beat = 1'b0;
        chk("race_state", 32'(dut.state), 32'(FIN));
        tick();
        rdchk("race_status", REG_STATUS, 32'h2);

        // abort mid-RUN
        wr(REG_CTRL, 32'h9);
        tick();
        dma_beat = 1'b1;
        tick();
        dma_beat = 1'b0;
        wr(REG_CTRL, 32'hC);
        chk("abort_rx",    32'(dma_rx_en), 32'd0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        rdchk("abort_status", REG_STATUS, 32'h8);
        chk("abort_irq", 32'(irq), 32'd1);

        // writes while busy are ignored
        wr(REG_TIMEOUT, 32'd100);
        wr(REG_LEN, 32'd4);
        wr(REG_CTRL, 32'h1);
        tick();
        dma_beat = 1'b1;
        tick();
        dma_beat = 1'b0;
        wr(REG_BASE, 32'h0000_2000);
        wr(REG_LEN, 32'd9);
        wr(REG_CTRL, 32'h3);
        rdchk("busy_base",   REG_BASE,   32'h0000_1000);
        rdchk("busy_len",    REG_LEN,    32'd4);
        rdchk("busy_remain", REG_REMAIN, 32'd3);
        rdchk("busy_ctrl",   REG_CTRL,   32'h0);
        chk("busy_dma_base", dma_base_addr,   32'h0000_1000);
        chk("busy_rx",       32'(dma_rx_en),  32'd1);
        chk("busy_tx",       32'(dma_tx_en),  32'd0);
        chk("busy_state",    32'(dut.state),  32'(RUN));
        dma_beat = 1'b1;
        repeat (3) tick();
        dma_beat = 1'b0;
        chk("busy_fin_state", 32'(dut.state), 32'(FIN));
        tick();
        dma_beat = 1'b1;
        tick();
        dma_beat = 1'b0;
        rdchk("nowrap_remain", REG_REMAIN, 32'd0);
        rdchk("busy_status",   REG_STATUS, 32'h2);

        // W1C touches only the written bits
        wr(REG_STATUS, 32'hC);
        rdchk("w1c_other_bits", REG_STATUS, 32'h2);
        wr(REG_STATUS, 32'h2);
        rdchk("w1c_done", REG_STATUS, 32'h0);

        // LEN=0 completes without enabling the DMA
        wr(REG_LEN, 32'd0);
        wr(REG_CTRL, 32'h1);
        chk("len0_state", 32'(dut.state), 32'(FIN));
        chk("len0_rx",    32'(dma_rx_en), 32'd0);
        chk("len0_tx",    32'(dma_tx_en), 32'd0);
        tick();
        chk("len0_rx2", 32'(dma_rx_en), 32'd0);
        chk("len0_tx2", 32'(dma_tx_en), 32'd0);
        rdchk("len0_status", REG_STATUS, 32'h2);

        // reset in the middle of RUN
        wr(REG_TIMEOUT, 32'd50);
        wr(REG_LEN, 32'd5);
        wr(REG_CTRL, 32'h9);
        tick();
        chk("mid_rx", 32'(dma_rx_en), 32'd1);
        s_rst = 1'b1;
        tick();
        chk("mid_rst_rx",    32'(dma_rx_en),  32'd0);
        chk("mid_rst_tx",    32'(dma_tx_en),  32'd0);
        chk("mid_rst_irq",   32'(irq),        32'd0);
        chk("mid_rst_base",  dma_base_addr,   32'd0);
        chk("mid_rst_dat_o", wb.wbs_dat_o,    32'd0);
        chk("mid_rst_state", 32'(dut.state),  32'(IDLE));
        s_rst = 1'b0;
        tick();
        rdchk("mid_rst_status",  REG_STATUS,  32'd0);
        rdchk("mid_rst_timeout", REG_TIMEOUT, 32'h00FF_FFFF);
        rdchk("mid_rst_len",     REG_LEN,     32'd0);
        rdchk("mid_rst_remain",  REG_REMAIN,  32'd0);
        rdchk("mid_rst_basereg", REG_BASE,    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
